// File: rtl/ps2_kb_rx_if.sv
// CPU-side bus between the PS/2 keyboard receiver and the keyboard peripheral port.
// Optional macro PS2_ERR_CNT_EN adds the err_cnt_o error counter to the bundle.
// The slave modport is the receiver; the master modport is the CPU-side bus logic.
interface ps2_kb_rx_if #(
    parameter int FIFO_AW = 3
);
    logic               rd_i;
    logic               clr_i;
    logic [7:0]         data_o;
    logic               valid_o;
    logic [FIFO_AW:0]   count_o;
    logic               ovf_o;
    logic               perr_o;
`ifdef PS2_ERR_CNT_EN
    logic [7:0]         err_cnt_o;

    modport master (
        output rd_i, clr_i,
        input  data_o, valid_o, count_o, ovf_o, perr_o, err_cnt_o
    );

    modport slave (
        input  rd_i, clr_i,
        output data_o, valid_o, count_o, ovf_o, perr_o, err_cnt_o
    );
`else
    modport master (
        output rd_i, clr_i,
        input  data_o, valid_o, count_o, ovf_o, perr_o
    );

    modport slave (
        input  rd_i, clr_i,
        output data_o, valid_o, count_o, ovf_o, perr_o
    );
`endif
endinterface

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receive front end: pad synchronisers, glitch filters, 11-bit frame
// deframer and a show-ahead byte FIFO read by the CPU one byte per rd_i pulse.
// Optional macro PS2_ERR_CNT_EN adds a saturating error counter (err_cnt_o).
module ps2_kb_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_AW     = 3
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            kb_clk_i,
    input  logic            kb_dat_i,
    ps2_kb_rx_if.slave      bus
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int FCW   = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TCW   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [1:0]         rstSync_q;
    logic               rstN;
    logic [1:0]         clkSync_q;
    logic [1:0]         datSync_q;
    logic [FCW-1:0]     clkFiltCnt_q;
    logic [FCW-1:0]     datFiltCnt_q;
    logic               clkFilt_q;
    logic               datFilt_q;
    logic               clkFiltDly_q;
    logic               fall;
    logic               bitIn;

    state_t             state_q;
    logic [2:0]         bitCnt_q;
    logic [7:0]         shReg_q;
    logic               frameBad_q;
    logic [TCW-1:0]     idleCnt_q;
    logic               timeout;
    logic               stopGood;
    logic               push;
    logic               frameErr;
    logic               perrSet;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wrPtr_q;
    logic [FIFO_AW-1:0] rdPtr_q;
    logic [FIFO_AW:0]   count_q;
    logic               full;
    logic               empty;
    logic               doPop;
    logic               doPush;
    logic               ovfSet;
    logic               ovf_q;
    logic               perr_q;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstN = rstSync_q[1];

    // Two-flop synchronisers for the asynchronous pads, preset to the idle-high bus level.
    always_ff @(posedge clk_i or negedge rstN) begin
        if (!rstN) begin
            clkSync_q <= 2'b11;
            datSync_q <= 2'b11;
        end else begin
            clkSync_q <= {clkSync_q[0], kb_clk_i};
            datSync_q <= {datSync_q[0], kb_dat_i};
        end
    end

    // Clock filter: level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk_i or negedge rstN) begin
        if (!rstN) begin
            clkFilt_q    <= 1'b1;
            clkFiltCnt_q <= '0;
        end else if (clkSync_q[1] == clkFilt_q) begin
            clkFiltCnt_q <= '0;
        end else if (clkFiltCnt_q == FCW'(FILTER_LEN - 1)) begin
            clkFilt_q    <= clkSync_q[1];
            clkFiltCnt_q <= '0;
        end else begin
            clkFiltCnt_q <= clkFiltCnt_q + 1'b1;
        end
    end

    // Data filter, identical to the clock filter so both see the same delay.
    always_ff @(posedge clk_i or negedge rstN) begin
        if (!rstN) begin
            datFilt_q    <= 1'b1;
            datFiltCnt_q <= '0;
        end else if (datSync_q[1] == datFilt_q) begin
            datFiltCnt_q <= '0;
        end else if (datFiltCnt_q == FCW'(FILTER_LEN - 1)) begin
            datFilt_q    <= datSync_q[1];
            datFiltCnt_q <= '0;
        end else begin
            datFiltCnt_q <= datFiltCnt_q + 1'b1;
        end
    end

    // Delayed copy of the filtered clock used to detect its falling edge.
    always_ff @(posedge clk_i or negedge rstN) begin
        if (!rstN) begin
            clkFiltDly_q <= 1'b1;
        end else begin
            clkFiltDly_q <= clkFilt_q;
        end
    end

    assign fall     = clkFiltDly_q & ~clkFilt_q;
    assign bitIn    = datFilt_q;
    assign timeout  = (state_q != IDLE) && (idleCnt_q == TCW'(TIMEOUT_CYC));
    assign stopGood = bitIn & ~frameBad_q;
    assign push     = fall && !timeout && (state_q == STOP) && stopGood;
    assign frameErr = fall && !timeout &&
                      (((state_q == IDLE) && bitIn) || ((state_q == STOP) && !stopGood));
    assign perrSet  = frameErr | timeout;

    // Frame deframer plus the mid-frame inactivity watchdog; a timeout overrides any bit.
    always_ff @(posedge clk_i or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            shReg_q    <= '0;
            frameBad_q <= 1'b0;
            idleCnt_q  <= '0;
        end else begin
            if (state_q == IDLE || fall) begin
                idleCnt_q <= '0;
            end else if (!timeout) begin
                idleCnt_q <= idleCnt_q + 1'b1;
            end

            if (timeout) begin
                state_q <= IDLE;
            end else if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!bitIn) begin
                            state_q    <= DATA;
                            bitCnt_q   <= '0;
                            frameBad_q <= 1'b0;
                        end
                    end
                    DATA: begin
                        shReg_q  <= {bitIn, shReg_q[7:1]};
                        bitCnt_q <= bitCnt_q + 1'b1;
                        if (bitCnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        if ((^{shReg_q, bitIn}) == 1'b0) begin
                            frameBad_q <= 1'b1;
                        end
                        state_q <= STOP;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign full   = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign doPop  = bus.rd_i && !empty;
    assign doPush = push && (!full || doPop);
    assign ovfSet = push && full && !doPop;

    // FIFO storage; contents need no reset because occupancy gates the output.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem[wrPtr_q] <= shReg_q;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the depth.
    always_ff @(posedge clk_i or negedge rstN) begin
        if (!rstN) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk_i or negedge rstN) begin
        if (!rstN) begin
            ovf_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (ovfSet) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_i) begin
                ovf_q <= 1'b0;
            end
            if (perrSet) begin
                perr_q <= 1'b1;
            end else if (bus.clr_i) begin
                perr_q <= 1'b0;
            end
        end
    end

`ifdef PS2_ERR_CNT_EN
    logic [7:0] errCnt_q;
    logic       errInc;

    assign errInc = perrSet | ovfSet;

    // Saturating count of every error event; a clear with a new error leaves one counted.
    always_ff @(posedge clk_i or negedge rstN) begin
        if (!rstN) begin
            errCnt_q <= '0;
        end else if (bus.clr_i) begin
            errCnt_q <= errInc ? 8'd1 : 8'd0;
        end else if (errInc && errCnt_q != 8'hFF) begin
            errCnt_q <= errCnt_q + 1'b1;
        end
    end

    assign bus.err_cnt_o = errCnt_q;
`endif

    assign bus.data_o  = empty ? 8'h00 : mem[rdPtr_q];
    assign bus.valid_o = !empty;
    assign bus.count_o = count_q;
    assign bus.ovf_o   = ovf_q;
    assign bus.perr_o  = perr_q;

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Directed testbench for ps2_kb_rx: a vector table of whole-frame / read / clear steps,
// followed by hand-written sequences for latency, full-FIFO read-at-push, timeout,
// glitch rejection and mid-frame reset. Define PS2_ERR_CNT_EN to also check err_cnt_o.
module tb_ps2_kb_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 300;
    localparam int FIFO_AW     = 3;
    localparam int HP          = 25;

    localparam int OP_FRAME = 0;
    localparam int OP_RD    = 1;
    localparam int OP_CLR   = 2;

    typedef struct {
        int         op;
        logic [7:0] dat;
        bit         badPar;
        bit         expValid;
        logic [7:0] expData;
        int         expCount;
        bit         expOvf;
        bit         expPerr;
        int         expErr;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_n_i;
    logic kb_clk_i;
    logic kb_dat_i;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    ps2_kb_rx_if #(.FIFO_AW(FIFO_AW)) busIf ();

    ps2_kb_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_AW    (FIFO_AW)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .kb_clk_i(kb_clk_i),
        .kb_dat_i(kb_dat_i),
        .bus     (busIf)
    );

    // 10-unit system clock.
    always #5 clk_i = ~clk_i;

    // Hard stop in case some sequence never returns.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input int op, input logic [7:0] dat, input bit badPar,
                                input bit expValid, input logic [7:0] expData,
                                input int expCount, input bit expOvf, input bit expPerr,
                                input int expErr);
        vec_t v;
        v.op = op; v.dat = dat; v.badPar = badPar;
        v.expValid = expValid; v.expData = expData; v.expCount = expCount;
        v.expOvf = expOvf; v.expPerr = expPerr; v.expErr = expErr;
        return v;
    endfunction

    function automatic bit oddPar(input logic [7:0] d);
        return ~(^d);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives the first nBits of a frame; kb_clk_i is left high afterwards.
    task automatic sendBits(input logic [7:0] d, input bit badPar, input int nBits);
        logic [10:0] f;
        f = {1'b1, oddPar(d) ^ badPar, d, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            kb_dat_i = f[i];
            tick(HP);
            kb_clk_i = 1'b0;
            tick(HP);
            kb_clk_i = 1'b1;
        end
    endtask

    task automatic sendFrame(input logic [7:0] d, input bit badPar);
        sendBits(d, badPar, 11);
        kb_dat_i = 1'b1;
        tick(HP);
    endtask

    task automatic pulseRd();
        busIf.rd_i = 1'b1;
        tick(1);
        busIf.rd_i = 1'b0;
        tick(1);
    endtask

    task automatic pulseClr();
        busIf.clr_i = 1'b1;
        tick(1);
        busIf.clr_i = 1'b0;
        tick(1);
    endtask

    task automatic applyStimulus(input vec_t v);
        case (v.op)
            OP_FRAME: sendFrame(v.dat, v.badPar);
            OP_RD:    pulseRd();
            default:  pulseClr();
        endcase
    endtask

    task automatic checkErrCnt(input string name, input int expected);
`ifdef PS2_ERR_CNT_EN
        checkOutput(name, 32'(busIf.err_cnt_o), expected);
`endif
    endtask

    initial begin
        int lat;
        int waited;

        rst_n_i     = 1'b0;
        kb_clk_i    = 1'b1;
        kb_dat_i    = 1'b1;
        busIf.rd_i  = 1'b0;
        busIf.clr_i = 1'b0;
        tick(3);
        checkOutput("reset valid", 32'(busIf.valid_o), 0);
        checkOutput("reset count", 32'(busIf.count_o), 0);
        checkOutput("reset data", 32'(busIf.data_o), 0);
        checkOutput("reset ovf", 32'(busIf.ovf_o), 0);
        checkOutput("reset perr", 32'(busIf.perr_o), 0);
        checkErrCnt("reset errcnt", 0);
        rst_n_i = 1'b1;
        tick(5);

        // op, byte, badPar, valid, data, count, ovf, perr, errcnt
        vecs.push_back(mk(OP_FRAME, 8'h1C, 0, 1, 8'h1C, 1, 0, 0, 0));
        vecs.push_back(mk(OP_RD,    8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(OP_FRAME, 8'hF0, 1, 0, 8'h00, 0, 0, 1, 1));
        vecs.push_back(mk(OP_CLR,   8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(OP_FRAME, 8'(k), 0, 1, 8'h01, k, 0, 0, 0));
        vecs.push_back(mk(OP_FRAME, 8'h09, 0, 1, 8'h01, 8, 1, 0, 1));
        for (int j = 1; j <= 7; j++)
            vecs.push_back(mk(OP_RD, 8'h00, 0, 1, 8'(1 + j), 8 - j, 1, 0, 1));
        vecs.push_back(mk(OP_RD,    8'h00, 0, 0, 8'h00, 0, 1, 0, 1));
        vecs.push_back(mk(OP_CLR,   8'h00, 0, 0, 8'h00, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d valid", i), 32'(busIf.valid_o), int'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d data", i), 32'(busIf.data_o), int'(vecs[i].expData));
            checkOutput($sformatf("vec%0d count", i), 32'(busIf.count_o), vecs[i].expCount);
            checkOutput($sformatf("vec%0d ovf", i), 32'(busIf.ovf_o), int'(vecs[i].expOvf));
            checkOutput($sformatf("vec%0d perr", i), 32'(busIf.perr_o), int'(vecs[i].expPerr));
            checkErrCnt($sformatf("vec%0d errcnt", i), vecs[i].expErr);
        end

        // Latency: 2 sync flops + 8 filter samples + edge register puts the push at the
        // 11th edge after the pad falls, so count/valid are visible after that edge.
        sendBits(8'h33, 0, 10);
        kb_dat_i = 1'b1;
        tick(HP);
        checkOutput("pre-stop count", 32'(busIf.count_o), 0);
        kb_clk_i = 1'b0;
        lat = 0;
        while (busIf.valid_o !== 1'b1 && lat < 40) begin
            tick(1);
            lat++;
        end
        checkOutput("stop-to-push latency", 32'(lat), 11);
        checkOutput("latency data", 32'(busIf.data_o), 8'h33);
        checkOutput("latency count", 32'(busIf.count_o), 1);
        checkOutput("latency perr", 32'(busIf.perr_o), 0);
        tick(HP);
        kb_clk_i = 1'b1;
        tick(HP);
        pulseRd();
        checkOutput("latency drain count", 32'(busIf.count_o), 0);

        // Full FIFO, with rd_i in the very cycle the 9th byte is pushed.
        for (int k = 0; k < 8; k++)
            sendFrame(8'(8'h10 + k), 0);
        checkOutput("full count", 32'(busIf.count_o), 8);
        sendBits(8'h18, 0, 10);
        kb_dat_i = 1'b1;
        tick(HP);
        kb_clk_i = 1'b0;
        tick(10);
        busIf.rd_i = 1'b1;
        tick(1);
        busIf.rd_i = 1'b0;
        checkOutput("rd-at-push count", 32'(busIf.count_o), 8);
        checkOutput("rd-at-push ovf", 32'(busIf.ovf_o), 0);
        tick(HP - 11);
        kb_clk_i = 1'b1;
        tick(HP);
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("rd-at-push head%0d", j), 32'(busIf.data_o), 8'h11 + j);
            pulseRd();
        end
        checkOutput("rd-at-push empty", 32'(busIf.valid_o), 0);
        checkErrCnt("rd-at-push errcnt", 0);

        // Timeout: start bit plus 4 data bits, then the keyboard clock stops.
        sendBits(8'hA5, 0, 5);
        kb_dat_i = 1'b1;
        tick(100);
        checkOutput("timeout early perr", 32'(busIf.perr_o), 0);
        waited = 0;
        while (busIf.perr_o !== 1'b1 && waited < 400) begin
            tick(1);
            waited++;
        end
        checkOutput("timeout perr", 32'(busIf.perr_o), 1);
        checkOutput("timeout count", 32'(busIf.count_o), 0);
        checkErrCnt("timeout errcnt", 1);
        sendFrame(8'h5A, 0);
        checkOutput("after timeout data", 32'(busIf.data_o), 8'h5A);
        checkOutput("after timeout count", 32'(busIf.count_o), 1);
        pulseClr();
        checkOutput("after timeout clr perr", 32'(busIf.perr_o), 0);
        pulseRd();

        // Short glitches on an idle bus must be filtered out entirely.
        for (int g = 0; g < 4; g++) begin
            kb_clk_i = 1'b0;
            tick(3);
            kb_clk_i = 1'b1;
            tick(20);
        end
        checkOutput("glitch perr", 32'(busIf.perr_o), 0);
        checkOutput("glitch count", 32'(busIf.count_o), 0);
        checkOutput("glitch valid", 32'(busIf.valid_o), 0);
        sendFrame(8'h7E, 0);
        checkOutput("post-glitch data", 32'(busIf.data_o), 8'h7E);
        checkOutput("post-glitch perr", 32'(busIf.perr_o), 0);

        // Reset in the middle of a frame with two bytes queued.
        sendFrame(8'h21, 0);
        checkOutput("pre-reset count", 32'(busIf.count_o), 2);
        sendBits(8'h44, 0, 6);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        checkOutput("async reset valid", 32'(busIf.valid_o), 0);
        checkOutput("async reset count", 32'(busIf.count_o), 0);
        checkOutput("async reset data", 32'(busIf.data_o), 0);
        tick(3);
        rst_n_i  = 1'b1;
        kb_dat_i = 1'b1;
        tick(5);
        checkOutput("post-reset count", 32'(busIf.count_o), 0);
        checkOutput("post-reset perr", 32'(busIf.perr_o), 0);
        sendFrame(8'h3C, 0);
        checkOutput("post-reset frame data", 32'(busIf.data_o), 8'h3C);
        checkOutput("post-reset frame count", 32'(busIf.count_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
